// File: rtl/multi_key_debounce.sv
// multi_key_debounce: N independent key channels, each a 2-flop synchroniser feeding a 4-state
// filter FSM; registered level, press/release pulses, any-event flag. Optional macro: LONG_PRESS_EN.
module multi_key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_CYCLES    = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] i_key,
  output logic [NUM_KEYS-1:0] o_key_state,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse,
  output logic                o_key_flag,
  output logic [NUM_KEYS-1:0] o_long_press
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_FILT,
    ST_DOWN,
    ST_RELEASE_FILT
  } state_t;

  if (NUM_KEYS < 1 || DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("multi_key_debounce: NUM_KEYS>=1, DEB_CYCLES>=2 and LONG_CYCLES>=2 required");
  end

  logic [NUM_KEYS-1:0] key_norm;
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_state_q;
  logic [NUM_KEYS-1:0] key_state_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] release_d;
  logic                key_flag_q;
  logic                key_flag_d;

  // Internally 1 always means pressed, so reset value 0 of the sync chain is "released".
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~i_key : i_key;

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k]     = state_q[k];
      cnt_d[k]       = cnt_q[k];
      key_state_d[k] = key_state_q[k];
      press_d[k]     = 1'b0;
      release_d[k]   = 1'b0;
      case (state_q[k])
        ST_IDLE: begin
          if (sync2_q[k]) begin
            state_d[k] = ST_PRESS_FILT;
            cnt_d[k]   = '0;
          end
        end
        ST_PRESS_FILT: begin
          if (!sync2_q[k]) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]     = ST_DOWN;
            cnt_d[k]       = '0;
            key_state_d[k] = 1'b1;
            press_d[k]     = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        ST_DOWN: begin
          if (!sync2_q[k]) begin
            state_d[k] = ST_RELEASE_FILT;
            cnt_d[k]   = '0;
          end
        end
        ST_RELEASE_FILT: begin
          if (sync2_q[k]) begin
            state_d[k] = ST_DOWN;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]     = ST_IDLE;
            cnt_d[k]       = '0;
            key_state_d[k] = 1'b0;
            release_d[k]   = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
    key_flag_d = (|press_d) | (|release_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      key_flag_q  <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1_q     <= key_norm;
      sync2_q     <= sync1_q;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      key_flag_q  <= key_flag_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  assign o_key_state     = key_state_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;
  assign o_key_flag      = key_flag_q;

`ifdef LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0]       hold_q [NUM_KEYS];
  logic [HW-1:0]       hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_done_q;
  logic [NUM_KEYS-1:0] long_done_d;
  logic [NUM_KEYS-1:0] long_q;
  logic [NUM_KEYS-1:0] long_d;

  // Hold time restarts on press acceptance and on accepted release; a rejected release bounce
  // keeps counting. long_done blocks a repeat pulse while the counter sits saturated.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      hold_d[k]      = hold_q[k];
      long_done_d[k] = long_done_q[k];
      long_d[k]      = 1'b0;
      if (state_d[k] == ST_IDLE || state_q[k] == ST_IDLE || state_q[k] == ST_PRESS_FILT) begin
        hold_d[k]      = '0;
        long_done_d[k] = 1'b0;
      end else if (hold_q[k] == HOLD_LAST) begin
        if (!long_done_q[k]) begin
          long_d[k]      = 1'b1;
          long_done_d[k] = 1'b1;
        end
      end else begin
        hold_d[k] = hold_q[k] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_done_q <= '0;
      long_q      <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      long_done_q <= long_done_d;
      long_q      <= long_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign o_long_press = long_q;
`else
  assign o_long_press = '0;
`endif

endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce: directed scenarios plus randomized key activity, all checked
// against a run-length reference model of the debounce rules.
module tb_multi_key_debounce;

  localparam int NK   = 4;
  localparam int DEB  = 16;
  localparam int LONG = 64;
`ifdef LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] i_key = '1;
  logic [NK-1:0] o_key_state;
  logic [NK-1:0] o_press_pulse;
  logic [NK-1:0] o_release_pulse;
  logic          o_key_flag;
  logic [NK-1:0] o_long_press;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multi_key_debounce #(
    .NUM_KEYS      (NK),
    .DEB_CYCLES    (DEB),
    .KEY_ACTIVE_LOW(1),
    .LONG_CYCLES   (LONG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_key          (i_key),
    .o_key_state    (o_key_state),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_key_flag     (o_key_flag),
    .o_long_press   (o_long_press)
  );

  // Reference model: a pin level reaches the filter two edges after it is sampled; a key's
  // accepted level flips once DEB+1 consecutive filter samples disagree with it.
  logic [NK-1:0] raw1, raw2;
  logic [NK-1:0] m_state, m_press, m_rel, m_long;
  logic          m_flag;
  int            run_len [NK];
  int            held    [NK];

  always @(posedge clk) begin
    logic [NK-1:0] seen;
    logic          was;
    if (rst) begin
      raw1 = '0; raw2 = '0;
      m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_flag = 1'b0;
      for (int k = 0; k < NK; k++) begin
        run_len[k] = 0;
        held[k]    = 0;
      end
    end else begin
      seen    = raw2;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < NK; k++) begin
        was = m_state[k];
        if (seen[k] != m_state[k]) run_len[k]++;
        else run_len[k] = 0;
        if (run_len[k] == DEB + 1) begin
          m_state[k] = ~m_state[k];
          run_len[k] = 0;
          if (m_state[k]) m_press[k] = 1'b1;
          else m_rel[k] = 1'b1;
        end
        if (was && m_state[k]) begin
          held[k]++;
          if (LP_EN && held[k] == LONG) m_long[k] = 1'b1;
        end else begin
          held[k] = 0;
        end
      end
      m_flag = |{m_press, m_rel};
      raw2   = raw1;
      raw1   = ~i_key;
    end
  end

  logic [4*NK:0] obs, exp_v;
  assign obs   = {o_key_state, o_press_pulse, o_release_pulse, o_key_flag, o_long_press};
  assign exp_v = {m_state, m_press, m_rel, m_flag, m_long};

  task automatic test_reset();
    rst   = 1'b1;
    i_key = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      vectors++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0", n, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    i_key[0] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== ((n == DEB + 2) ? 4'b0001 : 4'b0000) || o_key_flag !== (n == DEB + 2) ||
          o_key_state[0] !== (n >= DEB + 2)) begin
        errors++;
        $display("FAIL clean_press edge=%0d press=%b flag=%b state=%b", n, o_press_pulse, o_key_flag,
                 o_key_state);
      end
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press_model edge=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
    i_key[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (o_release_pulse !== ((n == DEB + 2) ? 4'b0001 : 4'b0000) || o_key_flag !== (n == DEB + 2) ||
          o_key_state[0] !== (n < DEB + 2)) begin
        errors++;
        $display("FAIL clean_release edge=%0d rel=%b flag=%b state=%b", n, o_release_pulse, o_key_flag,
                 o_key_state);
      end
    end
  endtask

  task automatic test_glitch();
    for (int n = 0; n < 40; n++) begin
      i_key[1] = (n < 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== 4'b0000 || o_key_state[1] !== 1'b0 || obs !== exp_v) begin
        errors++;
        $display("FAIL glitch cyc=%0d press=%b state=%b got=%h want=%h", n, o_press_pulse, o_key_state,
                 obs, exp_v);
      end
    end
    for (int n = 0; n < 30; n++) begin
      i_key[1] = ((n / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== 4'b0000 || obs !== exp_v) begin
        errors++;
        $display("FAIL bounce cyc=%0d press=%b got=%h want=%h", n, o_press_pulse, obs, exp_v);
      end
    end
    i_key[1] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== ((n == DEB + 2) ? 4'b0010 : 4'b0000) || obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_press edge=%0d press=%b got=%h want=%h", n, o_press_pulse, obs, exp_v);
      end
    end
    i_key[1] = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_release cyc=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    int flag_cycles = 0;
    i_key = 4'b0011;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (o_key_flag === 1'b1) flag_cycles++;
      vectors++;
      if (o_press_pulse !== ((n == DEB + 2) ? 4'b1100 : 4'b0000)) begin
        errors++;
        $display("FAIL simul_press edge=%0d got=%b", n, o_press_pulse);
      end
    end
    vectors++;
    if (flag_cycles !== 1) begin
      errors++;
      $display("FAIL simul_flag_cycles got=%0d want=1", flag_cycles);
    end
    i_key = '1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simul_release cyc=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_long_press();
    i_key[0] = 1'b0;
    for (int n = 0; n < DEB + 2 + 100; n++) begin
      @(negedge clk);
      // a short release bounce mid-hold must not restart the hold time
      i_key[0] = (n >= 40 && n < 43) ? 1'b1 : 1'b0;
      vectors++;
      if (o_long_press !== ((LP_EN && n == DEB + 2 + LONG) ? 4'b0001 : 4'b0000) ||
          o_key_flag !== (n == DEB + 2)) begin
        errors++;
        $display("FAIL long_press edge=%0d long=%b flag=%b", n, o_long_press, o_key_flag);
      end
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_model edge=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
    i_key[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (o_long_press !== 4'b0000 || obs !== exp_v) begin
        errors++;
        $display("FAIL long_release cyc=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    i_key[0] = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== 4'b0000 || obs !== exp_v) begin
        errors++;
        $display("FAIL midrst_pre edge=%0d got=%h want=%h", n, obs, exp_v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL midrst_cleared got=%h want=0", obs);
    end
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (o_press_pulse !== ((n == DEB + 2) ? 4'b0001 : 4'b0000) || obs !== exp_v) begin
        errors++;
        $display("FAIL midrst_press edge=%0d press=%b got=%h want=%h", n, o_press_pulse, obs, exp_v);
      end
    end
    i_key[0] = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_random();
    int hold_left [NK];
    for (int k = 0; k < NK; k++) hold_left[k] = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", n, obs, exp_v);
      end
      rst = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < NK; k++) begin
        if (hold_left[k] == 0) begin
          i_key[k]     = 1'($urandom_range(0, 1));
          hold_left[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 120))
                                                      : int'($urandom_range(1, 24));
        end else begin
          hold_left[k]--;
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_long_press();
    test_reset_mid_filter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
